// File: rtl/axi_ni_resp_packetizer_if.sv
// axi_ni_resp_packetizer_if: bus bundle for the NI response packetizer.
// Groups the request-notification, AXI B/R, route-LUT and out_buffer flit
// signals. The slave modport is the packetizer; the master modport is
// whatever surrounds it (request path, AXI slave, LUT and out_buffer).
interface axi_ni_resp_packetizer_if #(
  parameter int FLIT_WIDTH = 80,
  parameter int AXIDATAWD  = 64,
  parameter int IDWD       = 4,
  parameter int SRCWD      = 4,
  parameter int PATHWD     = 7
);
  logic                  req_valid;
  logic                  req_ready;
  logic [IDWD-1:0]       req_id;
  logic [SRCWD-1:0]      req_source;

  logic [IDWD-1:0]       BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [IDWD-1:0]       RID;
  logic [AXIDATAWD-1:0]  RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  logic [SRCWD-1:0]      lut_address;
  logic [PATHWD-1:0]     lut_path;

  logic [FLIT_WIDTH-1:0] flit_out;
  logic                  valid_out;
  logic                  stall_in;

  modport slave (
    input  req_valid, req_id, req_source,
    output req_ready,
    input  BID, BRESP, BVALID,
    output BREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output lut_address,
    input  lut_path,
    output flit_out, valid_out,
    input  stall_in
  );

  modport master (
    output req_valid, req_id, req_source,
    input  req_ready,
    output BID, BRESP, BVALID,
    input  BREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  lut_address,
    output lut_path,
    input  flit_out, valid_out,
    output stall_in
  );
endinterface

// File: rtl/axi_ni_resp_packetizer.sv
// axi_ni_resp_packetizer: NI target response-path engine.
// Records the requesting source of every outstanding AXI ID, then turns
// B responses and R bursts into head/body/tail flits for the out_buffer.
// B and R are arbitrated round-robin per packet; responses for an ID with
// nothing outstanding are swallowed and flagged in err_unexpected.
// Optional macro NI_RESP_STATS_EN adds saturating per-type packet counters.
module axi_ni_resp_packetizer #(
  parameter int FLIT_WIDTH    = 80,
  parameter int AXIDATAWD     = 64,
  parameter int IDWD          = 4,
  parameter int SRCWD         = 4,
  parameter int PATHWD        = 7,
  parameter int LOG_MAX_OUTST = 2,
  parameter logic [SRCWD-1:0] NI_SOURCE = 4'h8
) (
  input  logic clk,
  input  logic rst,
  axi_ni_resp_packetizer_if.slave bus,
  output logic err_unexpected
`ifdef NI_RESP_STATS_EN
  ,
  output logic [15:0] stat_b_pkts,
  output logic [15:0] stat_r_pkts
`endif
);

  localparam int NID    = 1 << IDWD;
  localparam int P_SRC  = PATHWD;
  localparam int P_RD   = PATHWD + SRCWD;
  localparam int P_ID   = P_RD + 1;
  localparam int P_RESP = P_ID + IDWD;

  localparam logic [LOG_MAX_OUTST-1:0] CNT_MAX = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]               state;
  logic [1:0]               next_state;
  logic                     rr_prefer_r;
  logic [IDWD-1:0]          lat_id;
  logic                     lat_read;
  logic [1:0]               lat_resp;
  logic [SRCWD-1:0]         lat_src;
  logic [LOG_MAX_OUTST-1:0] cnt     [NID];
  logic [SRCWD-1:0]         src_tab [NID];

  logic                     grant_any;
  logic                     grant_r;
  logic [IDWD-1:0]          grant_id;
  logic                     req_ok;
  logic                     req_fire;
  logic                     dec_en;
  logic [IDWD-1:0]          dec_id;

  // B wins unless only R is pending or the pointer currently favours R.
  assign grant_any = bus.BVALID || bus.RVALID;
  assign grant_r   = bus.RVALID && (!bus.BVALID || rr_prefer_r);
  assign grant_id  = grant_r ? bus.RID : bus.BID;

  // A new request is refused when the ID is full or already owned by another source.
  assign req_ok = !((cnt[bus.req_id] == CNT_MAX) ||
                    ((cnt[bus.req_id] != '0) && (src_tab[bus.req_id] != bus.req_source)));
  assign bus.req_ready = req_ok;
  assign req_fire      = bus.req_valid && req_ok;

  // Packet FSM outputs: flit formatting, AXI ready strobes and next state.
  always_comb begin
    next_state      = state;
    bus.valid_out   = 1'b0;
    bus.BREADY      = 1'b0;
    bus.RREADY      = 1'b0;
    bus.flit_out    = '0;
    bus.lut_address = '0;
    dec_en          = 1'b0;
    dec_id          = lat_id;
    case (state)
      S_IDLE: begin
        if (grant_any && !bus.stall_in)
          next_state = (cnt[grant_id] == '0) ? S_DROP : S_HEAD;
      end
      S_HEAD: begin
        bus.lut_address                   = lat_src;
        bus.flit_out[FLIT_WIDTH-1]        = 1'b1;
        bus.flit_out[FLIT_WIDTH-2]        = !lat_read;
        bus.flit_out[PATHWD-1:0]          = bus.lut_path;
        bus.flit_out[P_RD-1:P_SRC]        = NI_SOURCE;
        bus.flit_out[P_RD]                = lat_read;
        bus.flit_out[P_RESP-1:P_ID]       = lat_id;
        bus.flit_out[P_RESP+1:P_RESP]     = lat_resp;
        if (!bus.stall_in) begin
          bus.valid_out = 1'b1;
          if (lat_read) begin
            next_state = S_BODY;
          end else begin
            bus.BREADY = 1'b1;
            if (bus.BVALID) begin
              dec_en     = 1'b1;
              dec_id     = bus.BID;
              next_state = S_IDLE;
            end
          end
        end
      end
      S_BODY: begin
        bus.flit_out[FLIT_WIDTH-2]              = bus.RLAST;
        bus.flit_out[AXIDATAWD-1:0]             = bus.RDATA;
        bus.flit_out[AXIDATAWD+1:AXIDATAWD]     = bus.RRESP;
        if (!bus.stall_in) begin
          bus.RREADY    = 1'b1;
          bus.valid_out = bus.RVALID;
          if (bus.RVALID && bus.RLAST) begin
            dec_en     = 1'b1;
            dec_id     = bus.RID;
            next_state = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (!bus.stall_in) begin
          if (lat_read) begin
            bus.RREADY = 1'b1;
            if (bus.RVALID && bus.RLAST) next_state = S_IDLE;
          end else begin
            bus.BREADY = 1'b1;
            if (bus.BVALID) next_state = S_IDLE;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // FSM state, per-packet latches, round-robin pointer and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      rr_prefer_r    <= 1'b0;
      lat_id         <= '0;
      lat_read       <= 1'b0;
      lat_resp       <= 2'b00;
      lat_src        <= '0;
      err_unexpected <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && grant_any && !bus.stall_in) begin
        lat_id      <= grant_id;
        lat_read    <= grant_r;
        lat_resp    <= grant_r ? 2'b00 : bus.BRESP;
        lat_src     <= src_tab[grant_id];
        rr_prefer_r <= !grant_r;
        if (cnt[grant_id] == '0) err_unexpected <= 1'b1;
      end
    end
  end

  // ID table: count outstanding requests and remember their source; a
  // simultaneous increment and decrement on the same ID cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NID; i++) begin
        cnt[i]     <= '0;
        src_tab[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NID; i++) begin
        if (req_fire && (bus.req_id == IDWD'(i))) begin
          src_tab[i] <= bus.req_source;
          if (!(dec_en && (dec_id == IDWD'(i)))) cnt[i] <= cnt[i] + 1'b1;
        end else if (dec_en && (dec_id == IDWD'(i))) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

`ifdef NI_RESP_STATS_EN
  logic b_tail_wr;
  logic r_tail_wr;

  assign b_tail_wr = (state == S_HEAD) && !lat_read && !bus.stall_in;
  assign r_tail_wr = (state == S_BODY) && !bus.stall_in && bus.RVALID && bus.RLAST;

  // Saturating counters of delivered packets, bumped on each tail-flit write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_b_pkts <= 16'h0000;
      stat_r_pkts <= 16'h0000;
    end else begin
      if (b_tail_wr && (stat_b_pkts != 16'hFFFF)) stat_b_pkts <= stat_b_pkts + 16'd1;
      if (r_tail_wr && (stat_r_pkts != 16'hFFFF)) stat_r_pkts <= stat_r_pkts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_ni_resp_packetizer.sv
// tb_axi_ni_resp_packetizer: directed self-checking bench for the NI
// response packetizer. Flits written to the out_buffer are collected on the
// falling clock edge and compared against hand-built expected flits.
module tb_axi_ni_resp_packetizer;

  logic clk = 1'b0;
  logic rst;
  logic err_unexpected;
`ifdef NI_RESP_STATS_EN
  logic [15:0] stat_b_pkts;
  logic [15:0] stat_r_pkts;
`endif

  int tests  = 0;
  int failed = 0;
  int wb;
  int wr;
  logic [79:0] flits [$];

  axi_ni_resp_packetizer_if bus ();

  axi_ni_resp_packetizer dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .err_unexpected (err_unexpected)
`ifdef NI_RESP_STATS_EN
    ,
    .stat_b_pkts    (stat_b_pkts),
    .stat_r_pkts    (stat_r_pkts)
`endif
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Stand-in route LUT: path is the destination followed by 3'b011.
  function automatic logic [6:0] lut_fn(input logic [3:0] a);
    return {a, 3'b011};
  endfunction

  assign bus.lut_path = lut_fn(bus.lut_address);

  // Capture every out_buffer write away from the active edge.
  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) flits.push_back(bus.flit_out);
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [79:0] hdr(input logic [3:0] src, input logic rd,
                                      input logic [3:0] id, input logic [1:0] resp);
    logic [79:0] f;
    f         = '0;
    f[79]     = 1'b1;
    f[78]     = !rd;
    f[6:0]    = lut_fn(src);
    f[10:7]   = 4'h8;
    f[11]     = rd;
    f[15:12]  = id;
    f[17:16]  = resp;
    return f;
  endfunction

  function automatic logic [79:0] body(input logic [63:0] data, input logic [1:0] resp,
                                       input logic last);
    logic [79:0] f;
    f        = '0;
    f[63:0]  = data;
    f[65:64] = resp;
    f[78]    = last;
    return f;
  endfunction

  task automatic check_output(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_flit(input string tag, input logic [79:0] exp);
    logic [79:0] got;
    int n;
    n = flits.size();
    check_output({tag, " present"}, 80'(n != 0), 80'(1));
    if (n != 0) begin
      got = flits.pop_front();
      check_output(tag, got, exp);
    end
  endtask

  task automatic expect_no_more_flits(input string tag);
    check_output(tag, 80'(flits.size()), 80'(0));
    flits.delete();
  endtask

  task automatic send_req(input logic [3:0] id, input logic [3:0] src);
    bus.req_valid  = 1'b1;
    bus.req_id     = id;
    bus.req_source = src;
    @(negedge clk);
    check_output("req_ready_on_req", 80'(bus.req_ready), 80'(1));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic probe_ready(input string tag, input logic [3:0] id, input logic [3:0] src,
                             input logic exp);
    bus.req_valid  = 1'b0;
    bus.req_id     = id;
    bus.req_source = src;
    #1;
    check_output(tag, 80'(bus.req_ready), 80'(exp));
  endtask

  task automatic send_b(input logic [3:0] id, input logic [1:0] resp, output int waits);
    bit hs;
    hs          = 1'b0;
    waits       = 0;
    bus.BVALID  = 1'b1;
    bus.BID     = id;
    bus.BRESP   = resp;
    for (int c = 0; c < 64 && !hs; c++) begin
      @(negedge clk);
      waits++;
      if (bus.BREADY === 1'b1) hs = 1'b1;
      @(posedge clk); #1;
    end
    bus.BVALID = 1'b0;
    check_output("b_handshake", 80'(hs), 80'(1));
  endtask

  task automatic send_r_burst(input logic [3:0] id, input int n, input logic [63:0] base,
                              input logic [1:0] resp, input int stall_beat,
                              output int first_wait);
    bit hs;
    int w;
    first_wait = 0;
    for (int i = 0; i < n; i++) begin
      bus.RVALID = 1'b1;
      bus.RID    = id;
      bus.RDATA  = base + 64'(i);
      bus.RRESP  = resp;
      bus.RLAST  = (i == n - 1);
      if (i == stall_beat) begin
        bus.stall_in = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check_output("stall_valid_out", 80'(bus.valid_out), 80'(0));
          check_output("stall_rready", 80'(bus.RREADY), 80'(0));
          @(posedge clk); #1;
        end
        bus.stall_in = 1'b0;
      end
      hs = 1'b0;
      w  = 0;
      for (int c = 0; c < 64 && !hs; c++) begin
        @(negedge clk);
        w++;
        if (bus.RREADY === 1'b1) hs = 1'b1;
        @(posedge clk); #1;
      end
      check_output("r_handshake", 80'(hs), 80'(1));
      if (i == 0) first_wait = w;
      if (!hs) break;
    end
    bus.RVALID = 1'b0;
    bus.RLAST  = 1'b0;
  endtask

  initial begin
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_id     = '0;
    bus.req_source = '0;
    bus.BID        = '0;
    bus.BRESP      = '0;
    bus.BVALID     = 1'b0;
    bus.RID        = '0;
    bus.RDATA      = '0;
    bus.RRESP      = '0;
    bus.RLAST      = 1'b0;
    bus.RVALID     = 1'b0;
    bus.stall_in   = 1'b0;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    check_output("rst_req_ready", 80'(bus.req_ready), 80'(1));
    check_output("rst_bready", 80'(bus.BREADY), 80'(0));
    check_output("rst_rready", 80'(bus.RREADY), 80'(0));
    check_output("rst_valid_out", 80'(bus.valid_out), 80'(0));
    check_output("rst_flit_out", bus.flit_out, 80'(0));
    check_output("rst_lut_address", 80'(bus.lut_address), 80'(0));
    check_output("rst_err", 80'(err_unexpected), 80'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Single B packet: one head+tail flit, ID 3 freed afterwards.
    send_req(4'd3, 4'd2);
    probe_ready("id3_busy_other_src", 4'd3, 4'd9, 1'b0);
    send_b(4'd3, 2'b00, wb);
    check_output("b_latency", 80'(wb), 80'(2));
    expect_flit("b_flit", 80'hC0000000000000003413);
    expect_no_more_flits("b_flit_count");
    probe_ready("id3_freed", 4'd3, 4'd9, 1'b1);

    // Four-beat read: head, then bodies 0..3 with tail on the last.
    send_req(4'd1, 4'd5);
    send_r_burst(4'd1, 4, 64'd0, 2'b00, -1, wr);
    check_output("r_first_accept", 80'(wr), 80'(3));
    expect_flit("r_head", 80'h80000000000000001C2B);
    expect_flit("r_body0", body(64'd0, 2'b00, 1'b0));
    expect_flit("r_body1", body(64'd1, 2'b00, 1'b0));
    expect_flit("r_body2", body(64'd2, 2'b00, 1'b0));
    expect_flit("r_body3", body(64'd3, 2'b00, 1'b1));
    expect_no_more_flits("r_flit_count");

    // Conflict with the pointer on B: B packet then R packet.
    send_req(4'd2, 4'd6);
    send_req(4'd1, 4'd5);
    fork
      send_b(4'd2, 2'b01, wb);
      send_r_burst(4'd1, 2, 64'hA0, 2'b00, -1, wr);
    join
    expect_flit("c1_b", hdr(4'd6, 1'b0, 4'd2, 2'b01));
    expect_flit("c1_r_head", hdr(4'd5, 1'b1, 4'd1, 2'b00));
    expect_flit("c1_r_body0", body(64'hA0, 2'b00, 1'b0));
    expect_flit("c1_r_body1", body(64'hA1, 2'b00, 1'b1));
    expect_no_more_flits("c1_count");

    // Lone B packet moves the pointer to R.
    send_req(4'd4, 4'd3);
    send_b(4'd4, 2'b00, wb);
    expect_flit("lone_b", hdr(4'd3, 1'b0, 4'd4, 2'b00));
    expect_no_more_flits("lone_b_count");

    // Conflict with the pointer on R: R packet then B packet.
    send_req(4'd2, 4'd6);
    send_req(4'd1, 4'd5);
    fork
      send_b(4'd2, 2'b00, wb);
      send_r_burst(4'd1, 1, 64'hB0, 2'b00, -1, wr);
    join
    expect_flit("c2_r_head", hdr(4'd5, 1'b1, 4'd1, 2'b00));
    expect_flit("c2_r_body", body(64'hB0, 2'b00, 1'b1));
    expect_flit("c2_b", hdr(4'd6, 1'b0, 4'd2, 2'b00));
    expect_no_more_flits("c2_count");

    // Five-cycle stall in the middle of a burst.
    send_req(4'd1, 4'd5);
    send_r_burst(4'd1, 4, 64'h10, 2'b01, 2, wr);
    expect_flit("s_head", hdr(4'd5, 1'b1, 4'd1, 2'b00));
    expect_flit("s_body0", body(64'h10, 2'b01, 1'b0));
    expect_flit("s_body1", body(64'h11, 2'b01, 1'b0));
    expect_flit("s_body2", body(64'h12, 2'b01, 1'b0));
    expect_flit("s_body3", body(64'h13, 2'b01, 1'b1));
    expect_no_more_flits("s_count");

    // Source ownership and outstanding limit on ID 0.
    send_req(4'd0, 4'd1);
    probe_ready("id0_other_src", 4'd0, 4'd6, 1'b0);
    send_req(4'd0, 4'd1);
    send_req(4'd0, 4'd1);
    probe_ready("id0_full", 4'd0, 4'd1, 1'b0);
    send_b(4'd0, 2'b10, wb);
    expect_flit("id0_b1", hdr(4'd1, 1'b0, 4'd0, 2'b10));
    probe_ready("id0_partial", 4'd0, 4'd6, 1'b0);
    send_b(4'd0, 2'b10, wb);
    send_b(4'd0, 2'b10, wb);
    expect_flit("id0_b2", hdr(4'd1, 1'b0, 4'd0, 2'b10));
    expect_flit("id0_b3", hdr(4'd1, 1'b0, 4'd0, 2'b10));
    expect_no_more_flits("id0_count");
    probe_ready("id0_released", 4'd0, 4'd6, 1'b1);

    // Unexpected B on ID 7: swallowed, flagged, no flits.
    check_output("err_before_drop", 80'(err_unexpected), 80'(0));
    send_b(4'd7, 2'b00, wb);
    check_output("drop_bready_pulse", 80'(wb), 80'(2));
    #1;
    check_output("drop_bready_low", 80'(bus.BREADY), 80'(0));
    check_output("drop_err_set", 80'(err_unexpected), 80'(1));
    repeat (3) @(posedge clk);
    #1;
    check_output("drop_err_sticky", 80'(err_unexpected), 80'(1));
    expect_no_more_flits("drop_no_flits");

`ifdef NI_RESP_STATS_EN
    check_output("stat_b", 80'(stat_b_pkts), 80'(7));
    check_output("stat_r", 80'(stat_r_pkts), 80'(4));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
